// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and constants for the layer sequencer slice.
// Holds the FSM state encoding and a small integer helper.
package nn_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LRST,
        FILL,
        REQ,
        OUT
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Bundle of the controller, layer and downstream signals around the sequencer.
// The master modport is the sequencer's view of the bundle.
interface nn_layer_if #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 2
);
    logic                     start;
    logic [N_IN*DATA_W-1:0]   x_in;
    logic                     busy;
    logic                     layer_rst;
    logic                     fill;
    logic                     req;
    logic [N_IN*DATA_W-1:0]   x_layer;
    logic                     ack_layer;
    logic [DATA_W-1:0]        y_in;
    logic [DATA_W-1:0]        y_out;
    logic                     y_valid;
    logic                     y_ready;
    logic                     timeout_err;

    modport master (
        input  start, x_in, ack_layer, y_in, y_ready,
        output busy, layer_rst, fill, req, x_layer, y_out, y_valid, timeout_err
    );

    modport slave (
        output start, x_in, ack_layer, y_in, y_ready,
        input  busy, layer_rst, fill, req, x_layer, y_out, y_valid, timeout_err
    );
endinterface

// File: rtl/nn_layer_sequencer_timer.sv
// Loadable down-counter with a zero flag.
// Used for both the fill window and the request timeout.
module nn_seq_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/nn_layer_sequencer.sv
// Initiator side of the layer req/ack protocol: layer reset, fill, request,
// result capture and valid/ready hand-off downstream.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int N_IN        = 2,
    parameter int FILL_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic  clk,
    input  logic  rst,
    nn_layer_if.master bus
);
    localparam int TMAX = max_int(FILL_CYCLES, TIMEOUT);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] FILL_LOAD    = TW'(FILL_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT - 1);

    seq_state_t               r_state;
    seq_state_t               w_next;
    logic [N_IN*DATA_W-1:0]   r_x_layer;
    logic [DATA_W-1:0]        r_y_out;
    logic                     r_timeout_err;
    logic                     w_load;
    logic [TW-1:0]            w_load_val;
    logic                     w_dec;
    logic                     w_set_err;
    logic                     w_capture;
    logic                     w_zero;

    nn_seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_x_layer     <= '0;
            r_y_out       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && bus.start) begin
                r_x_layer <= bus.x_in;
            end
            if (w_capture) begin
                r_y_out <= bus.y_in;
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Ack is checked before the timer so a result on the last timeout cycle wins.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_set_err  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = LRST;
                end
            end
            LRST: begin
                w_next     = FILL;
                w_load     = 1'b1;
                w_load_val = FILL_LOAD;
            end
            FILL: begin
                if (w_zero) begin
                    w_next     = REQ;
                    w_load     = 1'b1;
                    w_load_val = TIMEOUT_LOAD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            REQ: begin
                if (bus.ack_layer) begin
                    w_capture = 1'b1;
                    w_next    = OUT;
                end else if (w_zero) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            OUT: begin
                if (bus.y_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.layer_rst   = (r_state == LRST);
    assign bus.fill        = (r_state == FILL);
    assign bus.req         = (r_state == REQ);
    assign bus.y_valid     = (r_state == OUT);
    assign bus.x_layer     = r_x_layer;
    assign bus.y_out       = r_y_out;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: main instance with default timing and a
// second instance with a single-cycle fill window.
module tb_nn_layer_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic sawValid;

    always #5 clk = ~clk;

    nn_layer_if #(.DATA_W(8), .N_IN(2)) bus ();
    nn_layer_if #(.DATA_W(8), .N_IN(2)) bus2 ();

    nn_layer_sequencer #(.DATA_W(8), .N_IN(2), .FILL_CYCLES(4), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    nn_layer_sequencer #(.DATA_W(8), .N_IN(2), .FILL_CYCLES(1), .TIMEOUT(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] x);
        bus.start = s;
        bus.x_in  = x;
    endtask

    task automatic waitReq(input string tag);
        n = 0;
        while (!bus.req && n < 50) begin
            n++;
            cyc();
        end
        checkOutput(tag, bus.req, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000);
        bus.ack_layer  = 1'b0;
        bus.y_in       = 8'h00;
        bus.y_ready    = 1'b0;
        bus2.start     = 1'b0;
        bus2.x_in      = 16'h0000;
        bus2.ack_layer = 1'b0;
        bus2.y_in      = 8'h00;
        bus2.y_ready   = 1'b0;
        cyc();
        cyc();
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_lrst", bus.layer_rst, 0);
        checkOutput("rst_fill", bus.fill, 0);
        checkOutput("rst_req", bus.req, 0);
        checkOutput("rst_xlayer", bus.x_layer, 0);
        checkOutput("rst_yout", bus.y_out, 0);
        checkOutput("rst_yvalid", bus.y_valid, 0);
        checkOutput("rst_err", bus.timeout_err, 0);
        rst = 1'b0;
        cyc();

        // Single-cycle fill window on the second instance
        bus2.y_ready = 1'b1;
        bus2.start   = 1'b1;
        bus2.x_in    = 16'h0304;
        cyc();
        bus2.start = 1'b0;
        checkOutput("f1_lrst", bus2.layer_rst, 1);
        cyc();
        n = 0;
        while (bus2.fill && n < 10) begin
            n++;
            cyc();
        end
        checkOutput("f1_fill_len", n, 1);
        checkOutput("f1_req", bus2.req, 1);
        bus2.ack_layer = 1'b1;
        bus2.y_in      = 8'h11;
        cyc();
        checkOutput("f1_yout", bus2.y_out, 32'h11);
        checkOutput("f1_yvalid", bus2.y_valid, 1);
        bus2.ack_layer = 1'b0;
        cyc();
        checkOutput("f1_idle", bus2.busy, 0);

        // Basic run
        applyStimulus(1'b1, 16'h1AE7);
        cyc();
        applyStimulus(1'b0, 16'h5555);
        checkOutput("t1_lrst", bus.layer_rst, 1);
        checkOutput("t1_busy", bus.busy, 1);
        checkOutput("t1_xlayer", bus.x_layer, 32'h1AE7);
        cyc();
        checkOutput("t1_lrst_pulse", bus.layer_rst, 0);
        n = 0;
        while (bus.fill && n < 20) begin
            n++;
            cyc();
        end
        checkOutput("t1_fill_len", n, 4);
        checkOutput("t1_req", bus.req, 1);
        repeat (5) cyc();
        checkOutput("t1_req_hold", bus.req, 1);
        checkOutput("t1_no_valid", bus.y_valid, 0);
        bus.ack_layer = 1'b1;
        bus.y_in      = 8'sd37;
        bus.y_ready   = 1'b1;
        cyc();
        checkOutput("t1_yvalid", bus.y_valid, 1);
        checkOutput("t1_yout", bus.y_out, 32'd37);
        checkOutput("t1_req_drop", bus.req, 0);
        checkOutput("t1_xstable", bus.x_layer, 32'h1AE7);
        cyc();
        checkOutput("t1_idle", bus.busy, 0);
        checkOutput("t1_yout_hold", bus.y_out, 32'd37);

        // Stale ack still high into the next start, then back-pressure
        bus.y_ready = 1'b0;
        applyStimulus(1'b1, 16'h0102);
        cyc();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t4_lrst", bus.layer_rst, 1);
        checkOutput("t4_hold_lrst", bus.y_out, 32'd37);
        cyc();
        bus.ack_layer = 1'b0;
        checkOutput("t4_fill", bus.fill, 1);
        checkOutput("t4_hold_fill", bus.y_out, 32'd37);
        checkOutput("t4_novalid", bus.y_valid, 0);
        waitReq("t4_wait_req");
        checkOutput("t4_hold_req", bus.y_out, 32'd37);
        bus.ack_layer = 1'b1;
        bus.y_in      = 8'hFB;
        cyc();
        checkOutput("t4_capture", bus.y_out, 32'hFB);
        applyStimulus(1'b1, 16'hAAAA);
        bus.y_in = 8'h66;
        for (int i = 0; i < 10; i++) begin
            checkOutput("t2_valid", bus.y_valid, 1);
            checkOutput("t2_yout", bus.y_out, 32'hFB);
            checkOutput("t2_busy", bus.busy, 1);
            checkOutput("t2_xlayer", bus.x_layer, 32'h0102);
            cyc();
        end
        bus.y_ready = 1'b1;
        cyc();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t2_idle", bus.busy, 0);
        checkOutput("t2_novalid", bus.y_valid, 0);
        cyc();
        checkOutput("t2_no_restart", bus.busy, 0);

        // Timeout: ack never rises in REQ
        applyStimulus(1'b1, 16'h0F0F);
        cyc();
        applyStimulus(1'b0, 16'h0000);
        cyc();
        bus.ack_layer = 1'b0;
        waitReq("t3_wait_req");
        n = 0;
        sawValid = 1'b0;
        while (bus.req && n < 200) begin
            if (bus.y_valid) sawValid = 1'b1;
            n++;
            cyc();
        end
        checkOutput("t3_req_len", n, 64);
        checkOutput("t3_err", bus.timeout_err, 1);
        checkOutput("t3_idle", bus.busy, 0);
        checkOutput("t3_novalid", sawValid | bus.y_valid, 0);
        checkOutput("t3_yout", bus.y_out, 32'hFB);
        repeat (3) cyc();
        checkOutput("t3_sticky", bus.timeout_err, 1);

        // Ack on the final timeout cycle
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checkOutput("t5_err_clr", bus.timeout_err, 0);
        applyStimulus(1'b1, 16'h2233);
        cyc();
        applyStimulus(1'b0, 16'h0000);
        cyc();
        waitReq("t5_wait_req");
        repeat (63) cyc();
        checkOutput("t5_req_last", bus.req, 1);
        bus.ack_layer = 1'b1;
        bus.y_in      = 8'h55;
        bus.y_ready   = 1'b1;
        cyc();
        checkOutput("t5_valid", bus.y_valid, 1);
        checkOutput("t5_yout", bus.y_out, 32'h55);
        checkOutput("t5_err", bus.timeout_err, 0);
        cyc();
        checkOutput("t5_err_after", bus.timeout_err, 0);

        // Reset during FILL
        applyStimulus(1'b1, 16'h4455);
        cyc();
        applyStimulus(1'b0, 16'h0000);
        bus.ack_layer = 1'b0;
        cyc();
        checkOutput("t6_fill", bus.fill, 1);
        rst = 1'b1;
        cyc();
        checkOutput("t6a_busy", bus.busy, 0);
        checkOutput("t6a_fill", bus.fill, 0);
        checkOutput("t6a_xlayer", bus.x_layer, 0);
        checkOutput("t6a_yout", bus.y_out, 0);
        rst = 1'b0;
        applyStimulus(1'b1, 16'h6677);
        cyc();
        applyStimulus(1'b0, 16'h0000);
        waitReq("t6a_wait_req");
        bus.ack_layer = 1'b1;
        bus.y_in      = 8'h80;
        bus.y_ready   = 1'b0;
        cyc();
        checkOutput("t6a_yout_run", bus.y_out, 32'h80);
        checkOutput("t6a_xlayer_run", bus.x_layer, 32'h6677);

        // Reset during OUT
        cyc();
        checkOutput("t6b_valid", bus.y_valid, 1);
        rst = 1'b1;
        bus.ack_layer = 1'b0;
        cyc();
        checkOutput("t6b_yvalid", bus.y_valid, 0);
        checkOutput("t6b_yout", bus.y_out, 0);
        checkOutput("t6b_busy", bus.busy, 0);
        rst = 1'b0;
        bus.y_ready = 1'b1;
        applyStimulus(1'b1, 16'h0809);
        cyc();
        applyStimulus(1'b0, 16'h0000);
        waitReq("t6b_wait_req");
        bus.ack_layer = 1'b1;
        bus.y_in      = 8'h22;
        cyc();
        checkOutput("t6b_yout_run", bus.y_out, 32'h22);
        checkOutput("t6b_valid_run", bus.y_valid, 1);
        cyc();
        checkOutput("t6b_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
